// File: rtl/qspi_sdram_fetch_pkg.sv
// ---------------------------------------------------------------------------
// qspi2sdram_pkg
//   Shared definitions for the qspi2sdram family of blocks:
//     - fetch_state_t : line-fetch FSM state encodings
//     - BURST_LEN_DEF : 16-bit words fetched per request (one 8x16 line)
//     - ACK_TIMEOUT_DEF : clk cycles allowed for the SDRAM to accept a read
//     - SYNC_STAGES_DEF : default depth of qspi_clk-domain synchronizers
// ---------------------------------------------------------------------------
package qspi2sdram_pkg;

    localparam int BURST_LEN_DEF   = 8;
    localparam int ACK_TIMEOUT_DEF = 255;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/qspi_sdram_fetch_sync_bit.sv
// ---------------------------------------------------------------------------
// qspi_sync_bit
//   Single-bit flop-chain synchronizer bringing a qspi_clk-domain level into
//   the clk domain. Depth is set by STAGES.
//
//   Ports:
//     clk  in  1  destination clock
//     rst  in  1  asynchronous active-high reset, clears the whole chain
//     d    in  1  asynchronous input level
//     q    out 1  synchronized level, STAGES clk cycles behind d
// ---------------------------------------------------------------------------
module qspi_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the sampled level down the chain; only chain[0] can go
    // metastable, the later stages give it time to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/qspi_sdram_fetch.sv
// ---------------------------------------------------------------------------
// qspi_sdram_fetch
//   Fetches one 8x16 line from SDRAM into a line RAM on behalf of a QSPI
//   slave running on its own clock. A request pulse from the qspi_clk domain
//   is synchronized, its rising edge latches the byte address, an SDRAM burst
//   read is issued and the returned words are written to the line RAM.
//
//   Ports:
//     clk                 in   1   system/SDRAM clock (only clock)
//     rst                 in   1   asynchronous active-high reset
//     qspi_rd_req         in   1   fetch request pulse (qspi_clk domain)
//     qspi_rd_addr        in   24  byte address of the line, stable
//     forbiden_autofresh  in   1   refresh inhibit level (qspi_clk domain)
//     qspi_rd_busy        out  1   fetch in progress, line RAM not valid
//     sdr_rd_req          out  1   SDRAM burst read request, held until ack
//     sdr_rd_addr         out  23  SDRAM word address
//     sdr_rd_ack          in   1   SDRAM accepted the request
//     sdr_rd_valid        in   1   returned data word valid
//     sdr_rd_data         in   16  returned data word
//     sdr_ref_inhibit     out  1   synchronized refresh inhibit
//     ram_wen             out  1   line RAM write strobe
//     ram_waddr           out  3   line RAM word address
//     ram_wdata           out  16  line RAM write data
//     err_timeout         out  1   sticky: SDRAM never acknowledged
//     err_overrun         out  1   sticky: request arrived while busy
//     err_clr             in   1   clears both sticky flags
// ---------------------------------------------------------------------------
module qspi_sdram_fetch
    import qspi2sdram_pkg::*;
#(
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        qspi_rd_req,
    input  logic [23:0] qspi_rd_addr,
    input  logic        forbiden_autofresh,
    output logic        qspi_rd_busy,
    output logic        sdr_rd_req,
    output logic [22:0] sdr_rd_addr,
    input  logic        sdr_rd_ack,
    input  logic        sdr_rd_valid,
    input  logic [15:0] sdr_rd_data,
    output logic        sdr_ref_inhibit,
    output logic        ram_wen,
    output logic [2:0]  ram_waddr,
    output logic [15:0] ram_wdata,
    output logic        err_timeout,
    output logic        err_overrun,
    input  logic        err_clr
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    fetch_state_t state, state_nxt;

    logic          req_sync;
    logic          req_sync_d;
    logic          req_edge;
    logic [22:0]   addr_q;
    logic [TW-1:0] ack_cnt;
    logic [2:0]    word_cnt;
    logic          timeout_hit;
    logic          write_en;
    logic          overrun_hit;
    logic          err_timeout_q;
    logic          err_overrun_q;

    // Byte address bit 0 never reaches the word-addressed SDRAM.
    logic unused_addr_bit;
    assign unused_addr_bit = qspi_rd_addr[0];

    qspi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (qspi_rd_req),
        .q   (req_sync)
    );

    qspi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_inhibit (
        .clk (clk),
        .rst (rst),
        .d   (forbiden_autofresh),
        .q   (sdr_ref_inhibit)
    );

    // The request pulse can be several clk cycles long, so only its rising
    // edge counts as a request.
    assign req_edge    = req_sync & ~req_sync_d;
    assign overrun_hit = req_edge && (state != ST_IDLE);

    // Next-state and output decode. The ack counter reaches ACK_TIMEOUT-1 in
    // the last REQ cycle, so the flag and the drop of sdr_rd_req appear
    // exactly ACK_TIMEOUT cycles after sdr_rd_req rose. An ack arriving in
    // that same cycle still wins.
    always_comb begin
        state_nxt    = state;
        timeout_hit  = 1'b0;
        write_en     = 1'b0;
        qspi_rd_busy = 1'b0;
        sdr_rd_req   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_edge) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                qspi_rd_busy = 1'b1;
                sdr_rd_req   = 1'b1;
                if (sdr_rd_ack) begin
                    state_nxt = ST_DATA;
                end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DATA: begin
                qspi_rd_busy = 1'b1;
                if (sdr_rd_valid) begin
                    write_en = 1'b1;
                    if (word_cnt == 3'(BURST_LEN - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The write port is a direct pass-through of the returned word so it
    // lands in the same cycle; data is forced to zero when not writing.
    assign ram_wen     = write_en;
    assign ram_waddr   = word_cnt;
    assign ram_wdata   = write_en ? sdr_rd_data : 16'h0000;
    assign sdr_rd_addr = addr_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

    // State, address capture, counters and sticky error flags. A new error
    // in the same cycle as err_clr wins so no event is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_sync_d    <= 1'b0;
            addr_q        <= '0;
            ack_cnt       <= '0;
            word_cnt      <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_sync_d <= req_sync;

            if (state == ST_IDLE && req_edge) begin
                addr_q <= qspi_rd_addr[23:1];
            end

            if (state == ST_REQ) begin
                ack_cnt <= ack_cnt + 1'b1;
            end else begin
                ack_cnt <= '0;
            end

            if (state == ST_IDLE) begin
                word_cnt <= '0;
            end else if (write_en) begin
                word_cnt <= word_cnt + 3'd1;
            end

            err_timeout_q <= (err_timeout_q & ~err_clr) | timeout_hit;
            err_overrun_q <= (err_overrun_q & ~err_clr) | overrun_hit;
        end
    end

endmodule

// File: tb/tb_qspi_sdram_fetch.sv
// ---------------------------------------------------------------------------
// tb_qspi_sdram_fetch
//   Directed testbench for qspi_sdram_fetch. Line RAM writes are predicted
//   into a queue when the words are driven; an independent monitor pops and
//   compares on every ram_wen.
// ---------------------------------------------------------------------------
module tb_qspi_sdram_fetch;

    localparam int ACK_TO = 255;
    localparam int SYNC   = 2;

    logic        clk;
    logic        rst;
    logic        qspi_rd_req;
    logic [23:0] qspi_rd_addr;
    logic        forbiden_autofresh;
    logic        qspi_rd_busy;
    logic        sdr_rd_req;
    logic [22:0] sdr_rd_addr;
    logic        sdr_rd_ack;
    logic        sdr_rd_valid;
    logic [15:0] sdr_rd_data;
    logic        sdr_ref_inhibit;
    logic        ram_wen;
    logic [2:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] exp_q[$];

    qspi_sdram_fetch #(
        .BURST_LEN   (8),
        .ACK_TIMEOUT (ACK_TO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .qspi_rd_req        (qspi_rd_req),
        .qspi_rd_addr       (qspi_rd_addr),
        .forbiden_autofresh (forbiden_autofresh),
        .qspi_rd_busy       (qspi_rd_busy),
        .sdr_rd_req         (sdr_rd_req),
        .sdr_rd_addr        (sdr_rd_addr),
        .sdr_rd_ack         (sdr_rd_ack),
        .sdr_rd_valid       (sdr_rd_valid),
        .sdr_rd_data        (sdr_rd_data),
        .sdr_ref_inhibit    (sdr_ref_inhibit),
        .ram_wen            (ram_wen),
        .ram_waddr          (ram_waddr),
        .ram_wdata          (ram_wdata),
        .err_timeout        (err_timeout),
        .err_overrun        (err_overrun),
        .err_clr            (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every line RAM write must match the oldest
    // predicted write; a write with nothing predicted is an error.
    always @(negedge clk) begin
        if (ram_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h expected no write",
                         ram_waddr, ram_wdata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check_output("ram_waddr", 32'(ram_waddr), 32'(e[18:16]));
                check_output("ram_wdata", 32'(ram_wdata), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_request(input logic [23:0] addr);
        qspi_rd_addr = addr;
        qspi_rd_req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        qspi_rd_req = 1'b0;
    endtask

    task automatic wait_sdr_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (sdr_rd_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // One fetch: request, ack three cycles after sdr_rd_req rises, then
    // n_words data words each preceded by a gap taken from gaps (3 bits per
    // word). A second request pulse is raised at word ovr_word (>=8: none).
    task automatic apply_stimulus(input logic [23:0] addr, input logic [22:0] exp_sdr,
                                  input logic [15:0] base, input logic [23:0] gaps,
                                  input int ovr_word, input int n_words);
        bit found;
        start_request(addr);
        wait_sdr_req(found);
        check_output("sdr_req_seen", 32'(found), 32'd1);
        check_output("sdr_rd_addr", 32'(sdr_rd_addr), 32'(exp_sdr));
        check_output("busy_in_req", 32'(qspi_rd_busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        sdr_rd_ack = 1'b1;
        @(posedge clk);
        #1;
        sdr_rd_ack = 1'b0;
        check_output("sdr_req_drop_after_ack", 32'(sdr_rd_req), 32'd0);
        for (int w = 0; w < n_words; w++) begin
            if (w == ovr_word)     qspi_rd_req = 1'b1;
            if (w == ovr_word + 2) qspi_rd_req = 1'b0;
            for (int g = 0; g < int'(gaps[w*3 +: 3]); g++) begin
                @(posedge clk);
                #1;
            end
            exp_q.push_back({3'(w), base + 16'(w)});
            sdr_rd_valid = 1'b1;
            sdr_rd_data  = base + 16'(w);
            @(posedge clk);
            #1;
            sdr_rd_valid = 1'b0;
            sdr_rd_data  = 16'h0000;
        end
        if (n_words == 8) begin
            check_output("busy_clear_after_last", 32'(qspi_rd_busy), 32'd0);
            check_output("sdr_req_idle_after_last", 32'(sdr_rd_req), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int c;
        bit found;

        rst                = 1'b1;
        qspi_rd_req        = 1'b0;
        qspi_rd_addr       = 24'h000000;
        forbiden_autofresh = 1'b1;
        sdr_rd_ack         = 1'b0;
        sdr_rd_valid       = 1'b0;
        sdr_rd_data        = 16'h0000;
        err_clr            = 1'b0;

        // Reset state, with the inhibit input high to show the chain is held.
        repeat (4) @(posedge clk);
        #1;
        check_output("rst_busy", 32'(qspi_rd_busy), 32'd0);
        check_output("rst_sdr_req", 32'(sdr_rd_req), 32'd0);
        check_output("rst_sdr_addr", 32'(sdr_rd_addr), 32'd0);
        check_output("rst_ram_wen", 32'(ram_wen), 32'd0);
        check_output("rst_ram_waddr", 32'(ram_waddr), 32'd0);
        check_output("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_output("rst_err_timeout", 32'(err_timeout), 32'd0);
        check_output("rst_err_overrun", 32'(err_overrun), 32'd0);
        check_output("rst_inhibit", 32'(sdr_ref_inhibit), 32'd0);
        forbiden_autofresh = 1'b0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] basic fetch");
        apply_stimulus(24'h012340, 23'h0091A0, 16'hA000, 24'h000000, 99, 8);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] gapped fetch");
        apply_stimulus(24'hABCDE0, 23'h55E6F0, 16'h1230,
                       {3'd1, 3'd2, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 99, 8);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] overrun during data");
        apply_stimulus(24'h7FFFF0, 23'h3FFFF8, 16'h5550, 24'h000000, 3, 8);
        check_output("err_overrun_set", 32'(err_overrun), 32'd1);
        check_output("err_timeout_quiet", 32'(err_timeout), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check_output("overrun_no_new_fetch", 32'(sdr_rd_req), 32'd0);
        check_output("overrun_busy_low", 32'(qspi_rd_busy), 32'd0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_output("err_overrun_cleared", 32'(err_overrun), 32'd0);

        // No ack: err_clr is held high throughout, so the flag rising at all
        // shows a new error wins over a simultaneous clear. Stray valids in
        // REQ must not write.
        $display("[TB] ack timeout");
        start_request(24'hFFFFF0);
        wait_sdr_req(found);
        check_output("to_sdr_req_seen", 32'(found), 32'd1);
        check_output("to_sdr_rd_addr", 32'(sdr_rd_addr), 32'h7FFFF8);
        err_clr      = 1'b1;
        sdr_rd_valid = 1'b1;
        sdr_rd_data  = 16'hDEAD;
        c = 0;
        for (int i = 1; i <= ACK_TO + 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                sdr_rd_valid = 1'b0;
                sdr_rd_data  = 16'h0000;
            end
            if (err_timeout === 1'b1) begin
                c = i;
                break;
            end
        end
        check_output("timeout_latency", 32'(c), 32'(ACK_TO));
        check_output("timeout_sdr_req_drop", 32'(sdr_rd_req), 32'd0);
        check_output("timeout_busy_clear", 32'(qspi_rd_busy), 32'd0);
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_output("err_timeout_cleared", 32'(err_timeout), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset after the 4th word, with a valid word still presented.
        $display("[TB] reset mid-fetch");
        apply_stimulus(24'h000100, 23'h000080, 16'hC000, 24'h000000, 99, 4);
        rst          = 1'b1;
        sdr_rd_valid = 1'b1;
        sdr_rd_data  = 16'hBEEF;
        #1;
        check_output("mid_rst_busy", 32'(qspi_rd_busy), 32'd0);
        check_output("mid_rst_ram_wen", 32'(ram_wen), 32'd0);
        check_output("mid_rst_ram_waddr", 32'(ram_waddr), 32'd0);
        check_output("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_output("mid_rst_sdr_addr", 32'(sdr_rd_addr), 32'd0);
        check_output("mid_rst_sdr_req", 32'(sdr_rd_req), 32'd0);
        @(posedge clk);
        #1;
        sdr_rd_valid = 1'b0;
        sdr_rd_data  = 16'h0000;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_rst_idle", 32'(qspi_rd_busy), 32'd0);
        apply_stimulus(24'h000200, 23'h000100, 16'hD000, 24'h000000, 99, 8);
        repeat (3) @(posedge clk);
        #1;

        // Inhibit is changed off the clock edge; it needs SYNC edges to show.
        $display("[TB] refresh inhibit");
        @(posedge clk);
        #3;
        forbiden_autofresh = 1'b1;
        lat = 0;
        while (sdr_ref_inhibit !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("inhibit_rise_latency", 32'(lat), 32'(SYNC));
        @(posedge clk);
        #4;
        forbiden_autofresh = 1'b0;
        lat = 0;
        while (sdr_ref_inhibit !== 1'b0 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("inhibit_fall_latency", 32'(lat), 32'(SYNC));

        repeat (5) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_sdram_fetch.md
QSPI_SDRAM_FETCH -- requirements
Module: qspi_sdram_fetch

Interface
REQ-001 Parameter BURST_LEN, default 8: 16-bit words fetched per request; fixed 8, matching the 8x16 line RAM.
REQ-002 Parameter ACK_TIMEOUT, default 255: clk cycles allowed from sdr_rd_req to sdr_rd_ack.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for qspi_clk-domain inputs.
REQ-004 clk  in  1  system/SDRAM clock; the block's only clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 qspi_rd_req  in  1  one-qspi_clk-wide fetch request pulse, qspi_clk domain.
REQ-007 qspi_rd_addr  in  24  byte address, bits[3:0]=0; stable from qspi_rd_req until the next request.
REQ-008 forbiden_autofresh  in  1  refresh-inhibit level, qspi_clk domain.
REQ-009 qspi_rd_busy  out  1  fetch in progress; line RAM not yet valid.
REQ-010 sdr_rd_req  out  1  SDRAM burst-read request, held until acked.
REQ-011 sdr_rd_addr  out  23  SDRAM word address = qspi_rd_addr[23:1].
REQ-012 sdr_rd_ack  in  1  one-cycle acceptance of sdr_rd_req.
REQ-013 sdr_rd_valid  in  1  one returned data word valid this cycle.
REQ-014 sdr_rd_data  in  16  returned data word.
REQ-015 sdr_ref_inhibit  out  1  synchronized forbiden_autofresh, to the refresh scheduler.
REQ-016 ram_wen  out  1  line RAM write strobe.
REQ-017 ram_waddr  out  3  line RAM word address.
REQ-018 ram_wdata  out  16  line RAM write data, equal to sdr_rd_data.
REQ-019 err_timeout  out  1  sticky flag: no ack within ACK_TIMEOUT cycles.
REQ-020 err_overrun  out  1  sticky flag: request arrived while busy.
REQ-021 err_clr  in  1  one-cycle clear of both error flags.

Function
REQ-022 qspi_rd_req and forbiden_autofresh SHALL each pass through a SYNC_STAGES flop chain; a request is the rising edge of the synchronized qspi_rd_req.
REQ-023 qspi_rd_addr SHALL be captured into a register on the cycle the request edge is detected; it is not synchronized per bit because it is stable.
REQ-024 FSM states SHALL be IDLE, REQ, DATA, DONE.
REQ-025 IDLE->REQ on request edge; qspi_rd_busy rises in the same cycle as the state change.
REQ-026 REQ: sdr_rd_req=1 with sdr_rd_addr from the captured address; on sdr_rd_ack go to DATA and drop sdr_rd_req the next cycle.
REQ-027 REQ: a timeout counter SHALL increment each cycle; when it reaches ACK_TIMEOUT, set err_timeout, drop sdr_rd_req, and go to DONE.
REQ-028 DATA: each sdr_rd_valid SHALL produce ram_wen=1 in the same cycle, with ram_waddr=word counter; the counter increments and wraps 7->0.
REQ-029 DATA->DONE on the 8th valid word; sdr_rd_valid outside DATA is ignored.
REQ-030 DONE SHALL last one cycle, clear qspi_rd_busy, and return to IDLE.
REQ-031 A request edge in REQ, DATA, or DONE SHALL be dropped and set err_overrun; the in-flight fetch completes unchanged.
REQ-032 If err_clr and a new error occur in the same cycle, the flag SHALL stay set.
REQ-033 sdr_ref_inhibit SHALL follow the synchronized forbiden_autofresh level, independent of FSM state.

Reset
REQ-034 On rst assertion: state=IDLE; qspi_rd_busy, sdr_rd_req, ram_wen, err_timeout, err_overrun, sdr_ref_inhibit=0; sdr_rd_addr, ram_waddr, ram_wdata=0; all synchronizers and counters=0.
REQ-035 On rst mid-fetch: the burst is abandoned with no further RAM writes; after release, the first request edge starts a clean fetch from word 0.

Structure
REQ-036 The FSM state encodings, BURST_LEN, and ACK_TIMEOUT defaults SHALL reside in a shared qspi2sdram package/include used by all qspi2sdram blocks.
REQ-037 One sub-module, qspi_sync_bit (parameterized-depth flop synchronizer), SHALL be instantiated twice.

Verification
REQ-038 qspi_rd_addr=24'h012340, one request pulse, ack after 3 cycles, 8 valid words 16'hA000..A007 -> sdr_rd_addr=23'h0091A0; ram_waddr 0..7 carries A000..A007; busy clears one cycle after the 8th word.
REQ-039 Request with ack never given -> err_timeout=1 exactly ACK_TIMEOUT cycles after sdr_rd_req rises; busy clears; no RAM writes.
REQ-040 Second request pulse during DATA -> err_overrun=1; exactly 8 writes occur; err_clr then clears the flag.
REQ-041 Valid words gapped by 0-5 idle cycles -> ram_waddr still sequential 0..7, no extra writes.
REQ-042 rst asserted after the 4th valid word -> all outputs at reset values immediately; the next request fetches all 8 words correctly.
REQ-043 forbiden_autofresh toggled asynchronously -> sdr_ref_inhibit follows within SYNC_STAGES+1 clk cycles.
